// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   state_e       : controller FSM states
//   DEFAULT_WIDTH : default operand / sum width in bits
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder.
//   a, b, cin : addend bits and carry-in
//   s, co     : sum bit and carry-out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, one bit per clock, LSB first.
//   clk, rst_n                : clock, async active-low reset
//   start_valid / start_ready : operand handshake (a, b, c_in sampled on accept)
//   result_valid / result_ready : result handshake (sum, c_out, ovf)
//   busy                      : high while an operation is running or its result is pending
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry),
        .s   (fa_s),
        .co  (fa_co)
    );

    // Handshake/status outputs decode the state register only.
    assign start_ready  = (state == StIdle);
    assign result_valid = (state == StDone);
    assign busy         = (state == StRun) || (state == StDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                        sum   <= '0;
                        state <= StRun;
                    end
                end
                StRun: begin
                    // Cell sum enters at the MSB; after WIDTH shifts bit 0 sits at sum[0].
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_co;
                    if (cnt == LAST) begin
                        // On the MSB cycle the carry flop holds the carry into the MSB.
                        c_out <= fa_co;
                        ovf   <= carry ^ fa_co;
                        state <= StDone;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StDone: begin
                    if (result_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that sequences a single 1-bit full-adder cell over two WIDTH-bit operands, one bit per clock, LSB first. It accepts operands through a valid/ready handshake, runs WIDTH add cycles with the carry held in a flop between bits, and presents the registered sum, carry-out and signed overflow through a second valid/ready handshake. It sits between an operand source (register file or test sequencer) and any consumer that tolerates WIDTH-cycle latency in exchange for minimal adder area.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start_valid  in  1  operands a, b, c_in are valid.
- start_ready  out  1  controller can accept operands; high only in IDLE.
- a  in  WIDTH  augend, sampled on accept.
- b  in  WIDTH  addend, sampled on accept.
- c_in  in  1  carry-in, sampled on accept.
- result_valid  out  1  sum, c_out and ovf are valid; high only in DONE.
- result_ready  in  1  consumer takes the result.
- sum  out  WIDTH  registered sum.
- c_out  out  1  registered final carry.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- **IDLE:** start_ready=1. On start_valid&&start_ready:
  - latch a and b into shift registers;
  - carry flop <= c_in; bit counter <= 0;
  - clear the sum shift register; go to RUN.
- **RUN:** each cycle the full-adder cell takes the shift-register LSBs and the carry flop.
  - Shift the cell sum into the sum register MSB end (right shift), so bit 0 ends at sum[0] after WIDTH shifts.
  - Shift operands right; carry flop <= cell carry; counter++.
  - When counter==WIDTH-2 is processed, capture carry into the MSB (the cell carry-in for bit WIDTH-1) for ovf.
  - When counter==WIDTH-1: c_out <= cell carry, ovf <= carry_into_msb ^ cell carry, go to DONE.
- **DONE:** result_valid=1; sum, c_out and ovf are held stable.
  - On result_ready, go to IDLE.
  - start_valid is ignored in DONE and RUN (start_ready=0).
- Inputs a, b and c_in may change freely after accept; they do not affect the operation in flight.
- Arithmetic: {c_out,sum} = a + b + c_in, exactly, modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH)+1 bits. There is no wrap beyond WIDTH-1.
- Reset mid-operation aborts with no partial result:
  - state -> IDLE; sum, c_out, ovf, counter and carry cleared;
  - result_valid=0 immediately (async).

## Timing
- Reset values: state IDLE, start_ready=1, result_valid=0, busy=0, sum=0, c_out=0, ovf=0.
- Accept at edge E0. Bits are processed at edges E1..E_WIDTH. result_valid rises after edge E_WIDTH, giving a latency of WIDTH cycles.
- The result handshake completes at the edge where result_valid&&result_ready. start_ready=1 from the next cycle.
- Minimum issue interval is WIDTH+2 cycles with result_ready held high.
- start_ready, result_valid and busy are decoded from the state register only, with no combinational input-to-output path.
- The async reset assertion is honoured mid-cycle. Deassertion is assumed synchronised upstream.

## Structure
- Package serial_add_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the DEFAULT_WIDTH=8 constant.
- Sub-module fa_cell is a combinational 1-bit full adder (a, b, cin -> s, co), instantiated once.
- Top level contains the FSM, counter, operand/sum shift registers, carry flop and result flops.

## Test plan
All scenarios use WIDTH=8.
- a=8'h3C, b=8'h05, c_in=0 -> sum=8'h41, c_out=0, ovf=0. result_valid rises exactly 8 cycles after the accept edge.
- a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1, ovf=0.
- a=8'h7F, b=8'h01, c_in=0 -> sum=8'h80, c_out=0, ovf=1. Also a=8'h80, b=8'h80 -> sum=8'h00, c_out=1, ovf=1.
- a=8'hFF, b=8'hFF, c_in=1 -> sum=8'hFF, c_out=1, ovf=0.
- Backpressure: hold result_ready=0 for 5 cycles in DONE while pulsing start_valid with new operands.
  - Outputs are stable and start_ready stays 0.
  - The new operands are not accepted.
  - After result_ready=1, IDLE and start_ready=1 follow on the next cycle.
- Reset: assert rst_n=0 after the 3rd RUN edge.
  - result_valid=0, sum=0 and busy=0 immediately.
  - After release, start_ready=1, and a following 8'h10+8'h20 gives 8'h30.
